muldiv_unit: RTL

//   Iterative RV32M/RV64M multiply/divide unit beside the integer ALU in the IEU.

---
 rtl/ieu_pkg.sv | 27 ++
 rtl/muldiv_core.sv | 38 +++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ieu_pkg.sv
// Shared IEU definitions: multiply/divide opcodes, unit state encoding and
// the shift-amount width helper used by both the ALU and the muldiv unit.
package ieu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Number of bits needed to index a bit position within an XLEN word.
  function automatic int SHAMT_LEN(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration of the muldiv datapath, purely combinational.
// Multiply: acc = {partial_hi, multiplier_lo}; add multiplicand when the
//   multiplier LSB is set, then shift the whole register right by one.
// Divide: acc = {remainder, quotient}; shift left by one and keep the trial
//   subtraction of the divisor only when it does not borrow.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Select between the shift-add and the restoring shift-subtract step.
  always_comb begin
    hi       = acc[2*XLEN-1:XLEN];
    lo       = acc[XLEN-1:0];
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    shifted  = {hi, lo[XLEN-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = acc;
    if (!is_div) begin
      acc_next = {sum, lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_next = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. Operands are reduced to
// magnitudes on accept, XLEN unsigned iterations run in muldiv_core, and
// the sign/special-case fix-up is applied when entering DONE. The result
// is held until the consumer takes it; flush kills any op in flight.
module muldiv_unit import ieu_pkg::*; #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_1,
  input  logic [XLEN-1:0] operand_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = SHAMT_LEN(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  muldiv_op_e        op_q;
  logic              div_q, a_neg_q, b_neg_q, div0_q, ovf_q;
  logic [XLEN-1:0]   dvd_q, opnd_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_step;

  muldiv_op_e        op_in;
  logic              div_in, s1_in, s2_in, a_neg_in, b_neg_in;
  logic              div0_in, ovf_in, early_in, accept, last;
  logic [XLEN-1:0]   a_mag, b_mag;

  // Turn the accumulated magnitude into the architectural result.
  function automatic logic [XLEN-1:0] fix_up(
    input muldiv_op_e        op,
    input logic [2*XLEN-1:0] acc,
    input logic              a_neg,
    input logic              b_neg,
    input logic              div0,
    input logic              ovf,
    input logic [XLEN-1:0]   dvd
  );
    logic signed [2*XLEN-1:0] prod;
    logic [XLEN-1:0]          quo, rem, res;
    prod = (a_neg ^ b_neg) ? -$signed(acc) : $signed(acc);
    quo  = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = div0 ? '1 : (ovf ? dvd : quo);
      default:                      res = div0 ? dvd : (ovf ? '0 : rem);
    endcase
    return res;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  // Decode the incoming request: signedness, magnitudes and early-out cases.
  always_comb begin
    op_in    = muldiv_op_e'(funct3);
    div_in   = funct3[2];
    s1_in    = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    s2_in    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg_in = s1_in && operand_1[XLEN-1];
    b_neg_in = s2_in && operand_2[XLEN-1];
    a_mag    = a_neg_in ? -operand_1 : operand_1;
    b_mag    = b_neg_in ? -operand_2 : operand_2;
    div0_in  = div_in && (operand_2 == '0);
    ovf_in   = div_in && !funct3[0] && (operand_1 == MIN_NEG) && (operand_2 == '1);
    early_in = EARLY_OUT && (div0_in || ovf_in);
    accept   = in_valid && in_ready && !flush;
    last     = (cnt_q == CNT_W'(XLEN-1));
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early_in ? DONE : BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Iteration counter, restarted on every accept.
  always_ff @(posedge clk) begin
    if (!reset_n)               cnt_q <= '0;
    else if (accept)            cnt_q <= '0;
    else if (state_q == BUSY)   cnt_q <= cnt_q + CNT_W'(1);
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .is_div   (div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_step)
  );

  // Operand capture on accept, then one datapath step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_in;
      div_q   <= div_in;
      a_neg_q <= a_neg_in;
      b_neg_q <= b_neg_in;
      div0_q  <= div0_in;
      ovf_q   <= ovf_in;
      dvd_q   <= operand_1;
      opnd_q  <= div_in ? b_mag : a_mag;
      acc_q   <= {{XLEN{1'b0}}, (div_in ? a_mag : b_mag)};
    end else if (state_q == BUSY) begin
      acc_q   <= acc_step;
    end
  end

  // Result register, written only on the way into DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q <= '0;
    end else if (accept && early_in) begin
      result_q <= fix_up(op_in, '0, a_neg_in, b_neg_in, div0_in, ovf_in, operand_1);
    end else if ((state_q == BUSY) && last && !flush) begin
      result_q <= fix_up(op_q, acc_step, a_neg_q, b_neg_q, div0_q, ovf_q, dvd_q);
    end
  end

endmodule
